// File: rtl/lamp_pattern_seq_if.sv
// rtl/lamp_pattern_seq_if.sv - command and lamp-bank signals for lamp_pattern_seq
interface lamp_pattern_seq_if #(
  parameter int N_LAMPS = 16
);
  logic               load;
  logic [3:0]         data_in;
  logic [N_LAMPS-1:0] lamp_ctl;
  logic               cycle_done;

  modport master (
    output load,
    output data_in,
    input  lamp_ctl,
    input  cycle_done
  );

  modport slave (
    input  load,
    input  data_in,
    output lamp_ctl,
    output cycle_done
  );
endinterface

// File: rtl/lamp_pattern_seq.sv
// rtl/lamp_pattern_seq.sv - prescaled running-lamp pattern sequencer
module lamp_pattern_seq #(
  parameter int N_LAMPS     = 16,
  parameter int STEP_CYCLES = 1
) (
  input logic              clk,
  input logic              reset,
  lamp_pattern_seq_if.slave bus
);

  // MODE and FILL folded into one state; bounce direction lives in dir.
  typedef enum logic [2:0] {
    S_HOLD,
    S_LEFT_DOT,
    S_RIGHT_DOT,
    S_BOUNCE_DOT,
    S_LEFT_BAR,
    S_RIGHT_BAR,
    S_BOUNCE_BAR
  } state_t;

  localparam int PRE_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(STEP_CYCLES - 1);
  localparam logic [N_LAMPS-1:0] PAT_LSB  = {{(N_LAMPS-1){1'b0}}, 1'b1};
  localparam logic [N_LAMPS-1:0] PAT_MSB  = {1'b1, {(N_LAMPS-1){1'b0}}};
  localparam logic [N_LAMPS-1:0] PAT_ALL  = {N_LAMPS{1'b1}};

  state_t             state, state_nxt;
  logic               inv, inv_nxt;
  logic               dir, dir_nxt;
  logic [N_LAMPS-1:0] pat, pat_nxt;
  logic [PRE_W-1:0]   pre, pre_nxt;
  logic               done_q, done_nxt;
  logic               step;
  logic [N_LAMPS-1:0] shifted;

  // State register; reset returns to HOLD with a dark pattern.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_HOLD;
      inv    <= 1'b0;
      dir    <= 1'b0;
      pat    <= '0;
      pre    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      inv    <= inv_nxt;
      dir    <= dir_nxt;
      pat    <= pat_nxt;
      pre    <= pre_nxt;
      done_q <= done_nxt;
    end
  end

  // Next-state: load restarts the pattern, otherwise step on prescaler wrap.
  always_comb begin
    state_nxt = state;
    inv_nxt   = inv;
    dir_nxt   = dir;
    pat_nxt   = pat;
    pre_nxt   = (pre == PRE_LAST) ? '0 : pre + 1'b1;
    done_nxt  = 1'b0;
    shifted   = '0;
    step      = !bus.load && (pre == PRE_LAST);

    if (bus.load) begin
      pre_nxt = '0;
      inv_nxt = bus.data_in[3];
      case (bus.data_in[2:0])
        3'b001:  state_nxt = S_LEFT_DOT;
        3'b010:  state_nxt = S_RIGHT_DOT;
        3'b011:  state_nxt = S_BOUNCE_DOT;
        3'b101:  state_nxt = S_LEFT_BAR;
        3'b110:  state_nxt = S_RIGHT_BAR;
        3'b111:  state_nxt = S_BOUNCE_BAR;
        default: state_nxt = S_HOLD;
      endcase
      // HOLD freezes whatever is showing; run modes restart from an end lamp.
      case (bus.data_in[1:0])
        2'b01, 2'b11: begin
          pat_nxt = PAT_LSB;
          dir_nxt = 1'b0;
        end
        2'b10: begin
          pat_nxt = PAT_MSB;
          dir_nxt = 1'b0;
        end
        default: ;
      endcase
    end else if (step) begin
      case (state)
        S_LEFT_DOT: begin
          pat_nxt  = {pat[N_LAMPS-2:0], pat[N_LAMPS-1]};
          done_nxt = pat[N_LAMPS-1];
        end
        S_RIGHT_DOT: begin
          pat_nxt  = {pat[0], pat[N_LAMPS-1:1]};
          done_nxt = pat[0];
        end
        S_LEFT_BAR: begin
          if (pat == PAT_ALL) begin
            pat_nxt  = '0;
            done_nxt = 1'b1;
          end else begin
            pat_nxt = {pat[N_LAMPS-2:0], 1'b1};
          end
        end
        S_RIGHT_BAR: begin
          if (pat == PAT_ALL) begin
            pat_nxt  = '0;
            done_nxt = 1'b1;
          end else begin
            pat_nxt = {1'b1, pat[N_LAMPS-1:1]};
          end
        end
        S_BOUNCE_DOT: begin
          if (!dir) begin
            shifted = pat << 1;
            dir_nxt = shifted[N_LAMPS-1];
          end else begin
            shifted  = pat >> 1;
            dir_nxt  = !shifted[0];
            done_nxt = shifted[0];
          end
          pat_nxt = shifted;
        end
        S_BOUNCE_BAR: begin
          if (!dir) begin
            shifted = {pat[N_LAMPS-2:0], 1'b1};
            dir_nxt = (shifted == PAT_ALL);
          end else begin
            shifted  = pat >> 1;
            dir_nxt  = (shifted != PAT_LSB);
            done_nxt = (shifted == PAT_LSB);
          end
          pat_nxt = shifted;
        end
        default: ;
      endcase
    end
  end

  assign bus.lamp_ctl   = pat ^ {N_LAMPS{inv}};
  assign bus.cycle_done = done_q;

endmodule

// File: doc/lamp_pattern_seq.md
# lamp_pattern_seq

Parametrised running-lamp controller: the next generation of the lab's simple lamp FSM, with configurable lamp count, step rate, direction, fill and bounce modes and output inversion. A 4-bit command word captured on `load` selects the pattern. The block then steps the lamp pattern at a prescaled rate and drives the lamp bank directly. It sits between the board's switch/button inputs and the LED bank in the FSM lab designs.

## Interface
- `N_LAMPS`, 16, number of lamps; legal range ≥ 4.
- `STEP_CYCLES`, 1, clock cycles per pattern step; legal range ≥ 1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load`  in  1  capture `data_in` as the new command and restart the pattern.
- `data_in`  in  4  command word; sampled only when `load`=1.
- `lamp_ctl`  out  N_LAMPS  lamp drive; bit 0 is the rightmost lamp.
- `cycle_done`  out  1  one-cycle pulse when a pattern period completes.

## Operation
- Command fields:
  - `data_in[1:0]` MODE: 00 HOLD, 01 LEFT, 10 RIGHT, 11 BOUNCE.
  - `data_in[2]` FILL: 0 single dot, 1 bar graph.
  - `data_in[3]` INV.
- Internal registers: `cfg[3:0]`, `pat[N_LAMPS-1:0]`, `dir` (0 = left), prescaler `pre` (0..STEP_CYCLES-1).
- Output: `lamp_ctl = pat ^ {N_LAMPS{cfg[3]}}`. It is decoded from registers only, with no combinational path from the inputs.
- Reset values: `cfg`=0, `pat`=0, `dir`=0, `pre`=0. Outputs after reset: `lamp_ctl`=0, `cycle_done`=0.
- Load:
  - `cfg` ← `data_in` and `pre` ← 0.
  - `pat` start value: LEFT/BOUNCE → 0…01 (`dir`=0); RIGHT → 10…0.
  - HOLD: `pat` is unchanged (freeze), `dir` unchanged.
- Step enable: `pre`==STEP_CYCLES-1 and `load`=0. `pre` wraps to 0 on the step enable and counts in every non-load cycle, in all modes.
- Steps are performed only when MODE≠HOLD.
- State machine on MODE/FILL/`dir`. Per step:
  - LEFT single: rotate left; bit N-1 → bit 0. `cycle_done` on the wrapping step.
  - RIGHT single: rotate right; bit 0 → bit N-1. `cycle_done` on the wrapping step.
  - LEFT fill: `pat` ← {pat[N-2:0],1} until all ones. The next step clears to 0 with `cycle_done`; the step after that gives 0…01. Period N+1 steps.
  - RIGHT fill: mirror of LEFT fill, inserting 1 at the MSB. Sequence: all ones → 0 (`cycle_done`) → 10…0.
  - BOUNCE single:
    - `dir`=0 shifts left; reaching bit N-1 sets `dir`=1.
    - `dir`=1 shifts right; reaching bit 0 sets `dir`=0 and pulses `cycle_done`.
    - Period 2N-2 steps.
  - BOUNCE fill:
    - `dir`=0: `pat` ← {pat[N-2:0],1}; reaching all ones sets `dir`=1.
    - `dir`=1: `pat` ← pat>>1; reaching 0…01 sets `dir`=0 and pulses `cycle_done`.
    - Period 2N-2 steps.
- A `pat` value illegal for the current mode (e.g. 0 in single mode, reachable only via HOLD after reset then a mode change) never occurs, because every run mode is entered via load.
- `data_in` is ignored when `load`=0.

## Timing
- Load at edge k: `lamp_ctl` shows the start pattern immediately after edge k.
- The first step is at edge k+STEP_CYCLES; subsequent steps every STEP_CYCLES edges.
- `cycle_done` is registered. It is high for exactly the one cycle following the completing step edge, aligned with the new `pat`.
- `load` held high: re-captures every cycle. `pat` is held at the start value, and there are no steps and no `cycle_done`.
- Priority: `reset` > `load` > step. Reset mid-run returns all registers to reset values at that edge.
- Load coincident with a step-enable cycle: the load wins, the step is discarded and `pre` ← 0.
- HOLD via load mid-run: `pat` freezes at its current value. `cycle_done` stays 0, while INV still applies from the new `cfg`.

## Test plan
- N=16, STEP_CYCLES=1; reset 2 cycles → `lamp_ctl`=0x0000, `cycle_done`=0; with no load, output stays 0x0000 for 20 cycles.
- Load 4'b0001 → 0x0001, 0x0002 … 0x8000, then 0x0001 with `cycle_done` high for exactly 1 cycle at the wrap. Repeat with 4'b1001 → 0xFFFE, 0xFFFD, ….
- Load 4'b0110 (RIGHT fill) → 0x8000, 0xC000 … 0xFFFF, then 0x0000 with `cycle_done`, then 0x8000. Period 17 steps.
- N=4, STEP_CYCLES=3, load 4'b0011 (BOUNCE single) → 1,2,4,8,4,2,1 (`cycle_done`), 2…, changing every 3 cycles. Load 4'b0111 → 1,3,7,F,7,3,1 (`cycle_done`).
- Mid-run in LEFT single at 0x0010: load 4'b1000 → `lamp_ctl`=0xFFEF and frozen for 30 cycles. Load 4'b0001 on a step-enable cycle → 0x0001, next step after STEP_CYCLES.
- Assert `reset` together with `load`=1 and `data_in`=4'b0001 mid-run → the next edge gives `lamp_ctl`=0 and HOLD (reset wins). Releasing reset with `load`=0 leaves 0x0000 frozen.
